// File: rtl/qpi_flash_responder.sv
// Flash-side QPI responder: decodes the controller's command stream and serves EBh quad reads
// from a byte-wide memory port. `QPI_RESPONDER_SWRESET_EN adds the 66h/99h software reset.
module qpi_flash_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flash_nCE,
  input  logic        flash_SCK,
  input  logic [3:0]  flash_IO_in,
  output logic [3:0]  flash_IO_out,
  output logic        flash_IO_oe,
  output logic [23:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_ready,
  input  logic [7:0]  mem_data,
  output logic        qpi_mode,
  output logic        cont_mode,
  output logic        underrun
);

  typedef enum logic [2:0] {IDLE, CMD, PARAM, ADDR, MODE, DUMMY, DATA, IGNORE} state_t;

  state_t state, state_n, cmd_next;

  logic [SYNC_STAGES-1:0]      sck_sync, nce_sync;
  logic [SYNC_STAGES-1:0][3:0] io_sync;
  logic       sck_s, nce_s, sck_d, nce_d;
  logic [3:0] io_s;
  logic       sck_rise, sck_fall, nce_rise, nce_fall;

  logic [3:0]  cnt;
  logic [19:0] sh;
  logic [1:0]  dummy_cfg, pend_cfg;
  logic        pend_cfg_valid, pend_qpi_on, pend_qpi_off, mode_done;
  logic        oe_reg, phase, data_valid;
  logic [7:0]  mem_buf, cur_byte, cmd_byte;
  logic [3:0]  lo_nib, dummy_last;
  logic [1:0]  outstanding;
  logic        fresh, have, cmd_last, set_qpi_on, set_qpi_off;
`ifdef QPI_RESPONDER_SWRESET_EN
  logic        rst_armed, pend_rsten, pend_swrst, set_rsten, set_swrst;
`endif

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign nce_s    = nce_sync[SYNC_STAGES-1];
  assign io_s     = io_sync[SYNC_STAGES-1];
  assign nce_fall = nce_d & ~nce_s;
  assign nce_rise = ~nce_d & nce_s;
  assign sck_rise = ~sck_d & sck_s & ~nce_s;
  assign sck_fall = sck_d & ~sck_s & ~nce_s;

  assign flash_IO_oe = oe_reg & ~flash_nCE;

  assign cmd_byte   = qpi_mode ? {sh[3:0], io_s} : {sh[6:0], io_s[0]};
  assign cmd_last   = qpi_mode ? (cnt == 4'd1) : (cnt == 4'd7);
  assign dummy_last = {1'b0, dummy_cfg, 1'b0} - 4'd1;

  // The memory answers in order; only the reply to the most recent fetch is kept.
  assign fresh    = mem_ready & ~mem_read & (outstanding == 2'd1);
  assign have     = data_valid | fresh;
  assign cur_byte = data_valid ? mem_buf : mem_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= '0;
      nce_sync <= '1;
      io_sync  <= '0;
      sck_d    <= 1'b0;
      nce_d    <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], flash_SCK};
      nce_sync <= {nce_sync[SYNC_STAGES-2:0], flash_nCE};
      io_sync  <= {io_sync[SYNC_STAGES-2:0], flash_IO_in};
      sck_d    <= sck_s;
      nce_d    <= nce_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    cmd_next    = IGNORE;
    set_qpi_on  = 1'b0;
    set_qpi_off = 1'b0;
`ifdef QPI_RESPONDER_SWRESET_EN
    set_rsten   = 1'b0;
    set_swrst   = 1'b0;
`endif
    state_n     = state;
    if (qpi_mode) begin
      case (cmd_byte)
        8'hFF:   set_qpi_off = 1'b1;
        8'hC0:   cmd_next = PARAM;
        8'hEB:   cmd_next = ADDR;
        default: ;
      endcase
    end else if (cmd_byte == 8'h38) begin
      set_qpi_on = 1'b1;
    end
`ifdef QPI_RESPONDER_SWRESET_EN
    if (cmd_byte == 8'h66)              set_rsten = 1'b1;
    if (cmd_byte == 8'h99 && rst_armed) set_swrst = 1'b1;
`endif
    if (nce_rise) begin
      state_n = IDLE;
    end else if (nce_fall) begin
      state_n = cont_mode ? ADDR : CMD;
    end else if (sck_rise) begin
      case (state)
        CMD:     if (cmd_last) state_n = cmd_next;
        PARAM:   if (cnt[0]) state_n = IGNORE;
        ADDR:    if (cnt == 4'd5) state_n = MODE;
        MODE:    if (cnt[0]) state_n = (dummy_cfg == 2'd0) ? DATA : DUMMY;
        DUMMY:   if (cnt == dummy_last) state_n = DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_IO_out   <= '0;
      mem_addr       <= '0;
      mem_read       <= 1'b0;
      qpi_mode       <= 1'b0;
      cont_mode      <= 1'b0;
      underrun       <= 1'b0;
      dummy_cfg      <= '0;
      pend_cfg       <= '0;
      pend_cfg_valid <= 1'b0;
      pend_qpi_on    <= 1'b0;
      pend_qpi_off   <= 1'b0;
      mode_done      <= 1'b0;
      oe_reg         <= 1'b0;
      phase          <= 1'b0;
      data_valid     <= 1'b0;
      mem_buf        <= '0;
      lo_nib         <= '0;
      outstanding    <= '0;
      cnt            <= '0;
      sh             <= '0;
`ifdef QPI_RESPONDER_SWRESET_EN
      rst_armed      <= 1'b0;
      pend_rsten     <= 1'b0;
      pend_swrst     <= 1'b0;
`endif
    end else begin
      mem_read <= 1'b0;
      if (mem_read && !mem_ready && outstanding != 2'd3)
        outstanding <= outstanding + 2'd1;
      else if (mem_ready && !mem_read && outstanding != 2'd0)
        outstanding <= outstanding - 2'd1;
      if (fresh) begin
        mem_buf    <= mem_data;
        data_valid <= 1'b1;
      end

      if (nce_rise) begin
        oe_reg     <= 1'b0;
        data_valid <= 1'b0;
        if (!mode_done)     cont_mode <= 1'b0;
        if (pend_qpi_on)    qpi_mode  <= 1'b1;
        if (pend_cfg_valid) dummy_cfg <= pend_cfg;
        if (pend_qpi_off) begin
          qpi_mode  <= 1'b0;
          cont_mode <= 1'b0;
        end
`ifdef QPI_RESPONDER_SWRESET_EN
        rst_armed <= pend_rsten;
        if (pend_swrst) begin
          qpi_mode  <= 1'b0;
          cont_mode <= 1'b0;
          dummy_cfg <= '0;
        end
`endif
      end else if (nce_fall) begin
        cnt            <= '0;
        oe_reg         <= 1'b0;
        phase          <= 1'b0;
        mode_done      <= 1'b0;
        pend_cfg_valid <= 1'b0;
        pend_qpi_on    <= 1'b0;
        pend_qpi_off   <= 1'b0;
`ifdef QPI_RESPONDER_SWRESET_EN
        pend_rsten     <= 1'b0;
        pend_swrst     <= 1'b0;
`endif
      end else if (sck_rise) begin
        cnt <= (state_n != state) ? 4'd0 : cnt + 4'd1;
        sh  <= (state == CMD && !qpi_mode) ? {sh[18:0], io_s[0]} : {sh[15:0], io_s};
        case (state)
          CMD: if (cmd_last) begin
            pend_qpi_on  <= set_qpi_on;
            pend_qpi_off <= set_qpi_off;
`ifdef QPI_RESPONDER_SWRESET_EN
            pend_rsten   <= set_rsten;
            pend_swrst   <= set_swrst;
`endif
          end
          PARAM: if (cnt[0]) begin
            pend_cfg       <= sh[1:0];
            pend_cfg_valid <= 1'b1;
          end
          ADDR: if (cnt == 4'd5) begin
            mem_addr   <= {sh[19:0], io_s};
            mem_read   <= 1'b1;
            data_valid <= 1'b0;
          end
          MODE: if (cnt[0]) begin
            mode_done <= 1'b1;
            cont_mode <= (sh[1:0] == 2'b10);
          end
          default: ;
        endcase
      end else if (sck_fall && state == DATA) begin
        oe_reg <= 1'b1;
        phase  <= ~phase;
        if (!phase) begin
          flash_IO_out <= have ? cur_byte[7:4] : 4'hF;
          lo_nib       <= have ? cur_byte[3:0] : 4'hF;
          if (!have) underrun <= 1'b1;
          mem_addr   <= mem_addr + 24'd1;
          mem_read   <= 1'b1;
          data_valid <= 1'b0;
        end else begin
          flash_IO_out <= lo_nib;
        end
      end
    end
  end

endmodule

// File: tb/tb_qpi_flash_responder.sv
// Directed bench for qpi_flash_responder: drives controller-side pin sequences and checks
// returned nibbles, mode flags and fetch behaviour against hand-computed values.
`timescale 1ns/1ps
module tb_qpi_flash_responder;

  logic        clk = 1'b0;
  logic        reset, flash_nCE, flash_SCK;
  logic [3:0]  flash_IO_in, flash_IO_out;
  logic        flash_IO_oe, mem_read, mem_ready, qpi_mode, cont_mode, underrun;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data;

  qpi_flash_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .flash_nCE(flash_nCE), .flash_SCK(flash_SCK),
    .flash_IO_in(flash_IO_in), .flash_IO_out(flash_IO_out), .flash_IO_oe(flash_IO_oe),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_ready(mem_ready), .mem_data(mem_data),
    .qpi_mode(qpi_mode), .cont_mode(cont_mode), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int oe_cnt = 0;
  int rd_cnt = 0;
  int cyc = 0;
  int ncyc = 0;
  logic [3:0]  s_io [64];
  logic        s_oe [64];
  logic [23:0] slow_addr = 24'hABCDEF;
  logic [23:0] q_addr [$];
  int          q_due [$];

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    case (a)
      24'h123454: return 8'hAB;
      24'h123455: return 8'hCD;
      24'h000007: return 8'hE7;
      24'hFFFFFE: return 8'h5E;
      24'hFFFFFF: return 8'h6F;
      24'h000000: return 8'h70;
      24'h000100: return 8'h3C;
      24'h000101: return 8'h4D;
      default:    return 8'h11;
    endcase
  endfunction

  // In-order memory model: fixed 2-clk latency, 40 clk for slow_addr.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flash_IO_oe) oe_cnt <= oe_cnt + 1;
    if (mem_read) begin
      rd_cnt <= rd_cnt + 1;
      q_addr.push_back(mem_addr);
      q_due.push_back(cyc + ((mem_addr == slow_addr) ? 40 : 2));
    end
    mem_ready <= 1'b0;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      mem_ready <= 1'b1;
      mem_data  <= mem_val(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sck_pulse(input logic [3:0] io);
    flash_IO_in = io;
    clk_wait(3);
    flash_SCK = 1'b1;
    clk_wait(6);
    flash_SCK = 1'b0;
    clk_wait(5);
    if (ncyc < 64) begin
      s_io[ncyc] = flash_IO_out;
      s_oe[ncyc] = flash_IO_oe;
    end
    ncyc++;
  endtask

  task automatic txn_begin();
    flash_nCE = 1'b0;
    ncyc = 0;
    clk_wait(4);
  endtask

  task automatic txn_end();
    clk_wait(3);
    flash_nCE = 1'b1;
    clk_wait(6);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sck_pulse({3'b111, b[i]});
  endtask

  task automatic qpi_byte(input logic [7:0] b);
    sck_pulse(b[7:4]);
    sck_pulse(b[3:0]);
  endtask

  task automatic spi_txn(input logic [7:0] b);
    txn_begin(); spi_byte(b); txn_end();
  endtask

  task automatic qpi_txn1(input logic [7:0] c);
    txn_begin(); qpi_byte(c); txn_end();
  endtask

  task automatic qpi_txn2(input logic [7:0] c, input logic [7:0] p);
    txn_begin(); qpi_byte(c); qpi_byte(p); txn_end();
  endtask

  task automatic qpi_read(input logic with_cmd, input logic [23:0] a, input logic [7:0] m,
                          input int extra);
    txn_begin();
    if (with_cmd) qpi_byte(8'hEB);
    qpi_byte(a[23:16]); qpi_byte(a[15:8]); qpi_byte(a[7:0]); qpi_byte(m);
    for (int i = 0; i < extra; i++) sck_pulse(4'h0);
    txn_end();
  endtask

  task automatic test_reset();
    reset = 1'b1; flash_nCE = 1'b1; flash_SCK = 1'b0; flash_IO_in = 4'h0;
    clk_wait(4);
    n_cmp++;
    if ({flash_IO_out, flash_IO_oe, mem_addr, mem_read, qpi_mode, cont_mode, underrun} !== 34'h0) begin
      n_bad++;
      $display("FAIL reset_state: got out=%h oe=%b addr=%h rd=%b qpi=%b cont=%b ur=%b, want all zero",
               flash_IO_out, flash_IO_oe, mem_addr, mem_read, qpi_mode, cont_mode, underrun);
    end
    n_cmp++;
    if (dut.dummy_cfg !== 2'd0) begin
      n_bad++; $display("FAIL reset_dummy_cfg: got %0d want 0", dut.dummy_cfg);
    end
    reset = 1'b0;
    clk_wait(4);
  endtask

  task automatic test_spi_cmds();
    int oe0;
    oe0 = oe_cnt;
    spi_txn(8'hFF);
    n_cmp++;
    if ({qpi_mode, cont_mode} !== 2'b00) begin
      n_bad++; $display("FAIL spi_ffh: got qpi=%b cont=%b want 0 0", qpi_mode, cont_mode);
    end
    spi_txn(8'h38);
    n_cmp++;
    if ({qpi_mode, cont_mode} !== 2'b10) begin
      n_bad++; $display("FAIL spi_38h: got qpi=%b cont=%b want 1 0", qpi_mode, cont_mode);
    end
    n_cmp++;
    if (oe_cnt !== oe0) begin
      n_bad++; $display("FAIL spi_no_drive: got %0d oe cycles want 0", oe_cnt - oe0);
    end
  endtask

  task automatic test_quad_read();
    logic [3:0] exp [4];
    exp = '{4'hA, 4'hB, 4'hC, 4'hD};
    qpi_txn2(8'hC0, 8'h00);
    qpi_read(1'b1, 24'h123454, 8'h20, 3);
    n_cmp++;
    if (s_oe[8] !== 1'b0) begin
      n_bad++; $display("FAIL quad_oe_early: got oe=%b at mode clock 1 want 0", s_oe[8]);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (s_io[9+i] !== exp[i] || s_oe[9+i] !== 1'b1) begin
        n_bad++;
        $display("FAIL quad_nib%0d: got %h oe=%b want %h oe=1", i, s_io[9+i], s_oe[9+i], exp[i]);
      end
    end
    n_cmp++;
    if ({cont_mode, flash_IO_oe} !== 2'b10) begin
      n_bad++; $display("FAIL quad_cont_release: got cont=%b oe=%b want 1 0", cont_mode, flash_IO_oe);
    end
    n_cmp++;
    if (mem_addr !== 24'h123456) begin
      n_bad++; $display("FAIL quad_addr_inc: got %h want 123456", mem_addr);
    end
  endtask

  task automatic test_cont_read();
    qpi_read(1'b0, 24'h000007, 8'h20, 1);
    n_cmp++;
    if (s_io[7] !== 4'hE || s_io[8] !== 4'h7 || s_oe[6] !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_read: got %h%h oe6=%b want E7 oe6=0", s_io[7], s_io[8], s_oe[6]);
    end
    n_cmp++;
    if (cont_mode !== 1'b1) begin
      n_bad++; $display("FAIL cont_kept: got %b want 1", cont_mode);
    end
    spi_txn(8'hFF);
    n_cmp++;
    if ({qpi_mode, cont_mode} !== 2'b10) begin
      n_bad++; $display("FAIL cont_exit: got qpi=%b cont=%b want 1 0", qpi_mode, cont_mode);
    end
  endtask

  task automatic test_dummy_wrap();
    logic [3:0] exp [6];
    exp = '{4'h5, 4'hE, 4'h6, 4'hF, 4'h7, 4'h0};
    qpi_txn2(8'hC0, 8'h30);
    qpi_read(1'b1, 24'hFFFFFE, 8'h00, 11);
    n_cmp++;
    if (s_oe[14] !== 1'b0) begin
      n_bad++; $display("FAIL dummy_oe_early: got oe=%b at last dummy want 0", s_oe[14]);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (s_io[15+i] !== exp[i] || s_oe[15+i] !== 1'b1) begin
        n_bad++;
        $display("FAIL wrap_nib%0d: got %h oe=%b want %h oe=1", i, s_io[15+i], s_oe[15+i], exp[i]);
      end
    end
    n_cmp++;
    if (mem_addr !== 24'h000001 || cont_mode !== 1'b0) begin
      n_bad++; $display("FAIL wrap_addr: got %h cont=%b want 000001 cont=0", mem_addr, cont_mode);
    end
  endtask

  task automatic test_underrun();
    logic [3:0] exp [4];
    exp = '{4'hF, 4'hF, 4'h4, 4'hD};
    qpi_txn2(8'hC0, 8'h00);
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++; $display("FAIL underrun_pre: got %b want 0", underrun);
    end
    slow_addr = 24'h000100;
    qpi_read(1'b1, 24'h000100, 8'h00, 3);
    slow_addr = 24'hABCDEF;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (s_io[9+i] !== exp[i]) begin
        n_bad++; $display("FAIL underrun_nib%0d: got %h want %h", i, s_io[9+i], exp[i]);
      end
    end
    n_cmp++;
    if (underrun !== 1'b1) begin
      n_bad++; $display("FAIL underrun_flag: got %b want 1", underrun);
    end
  endtask

  task automatic test_abort();
    int oe0, rd0;
    oe0 = oe_cnt;
    rd0 = rd_cnt;
    txn_begin();
    qpi_byte(8'hEB);
    sck_pulse(4'h1); sck_pulse(4'h2); sck_pulse(4'h3);
    txn_end();
    n_cmp++;
    if (oe_cnt !== oe0 || rd_cnt !== rd0) begin
      n_bad++;
      $display("FAIL abort_quiet: got %0d oe cycles %0d fetches want 0 0", oe_cnt - oe0, rd_cnt - rd0);
    end
    qpi_read(1'b1, 24'h123455, 8'h00, 1);
    n_cmp++;
    if (s_io[9] !== 4'hC || s_io[10] !== 4'hD) begin
      n_bad++; $display("FAIL abort_recover: got %h%h want CD", s_io[9], s_io[10]);
    end
  endtask

  task automatic test_swreset();
    qpi_txn2(8'hC0, 8'h30);
    qpi_txn1(8'h66);
    qpi_txn1(8'h99);
`ifdef QPI_RESPONDER_SWRESET_EN
    n_cmp++;
    if ({qpi_mode, dut.dummy_cfg, underrun} !== 4'b0001) begin
      n_bad++;
      $display("FAIL swreset: got qpi=%b cfg=%0d ur=%b want 0 0 1", qpi_mode, dut.dummy_cfg, underrun);
    end
    spi_txn(8'h38);
`else
    n_cmp++;
    if ({qpi_mode, dut.dummy_cfg, underrun} !== 4'b1111) begin
      n_bad++;
      $display("FAIL swreset_off: got qpi=%b cfg=%0d ur=%b want 1 3 1", qpi_mode, dut.dummy_cfg, underrun);
    end
`endif
  endtask

  task automatic test_qpi_exit();
    n_cmp++;
    if (qpi_mode !== 1'b1) begin
      n_bad++; $display("FAIL qpi_exit_pre: got %b want 1", qpi_mode);
    end
    qpi_txn1(8'hFF);
    n_cmp++;
    if ({qpi_mode, cont_mode} !== 2'b00) begin
      n_bad++; $display("FAIL qpi_exit: got qpi=%b cont=%b want 0 0", qpi_mode, cont_mode);
    end
  endtask

  initial begin
    reset = 1'b1; flash_nCE = 1'b1; flash_SCK = 1'b0; flash_IO_in = 4'h0;
    test_reset();
    test_spi_cmds();
    test_quad_read();
    test_cont_read();
    test_dummy_wrap();
    test_underrun();
    test_abort();
    test_swreset();
    test_qpi_exit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
